edge_detector_stream: RTL
=========================

# edge_detector_stream

Streaming, parametrised 3x3 Sobel edge detector. It accepts a grayscale frame in raster order over a valid/ready handshake and emits the interior (IMG_X_SIZE-2)x(IMG_Y_SIZE-2) result pixels on a second valid/ready stream. Two internal line buffers replace full-frame storage. The block supersedes the store-then-process edge detector in the image pipeline and adds run-time mode selection, thresholding, backpressure and frame-done signalling.

## Interface
- PIX_W, 8, pixel width in bits (input and output).
- IMG_X_SIZE, 100, frame width in pixels (>=3).
- IMG_Y_SIZE, 100, frame height in pixels (>=3).
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- start_i  in  1  frame start pulse; honoured only in IDLE.
- mode_i  in  2  0=|Gx|, 1=|Gy|, 2=|Gx|+|Gy|, 3=binary threshold of |Gx|+|Gy|; latched on accepted start.
- thresh_i  in  PIX_W+3  threshold for mode 3; latched on accepted start.
- pix_valid_i  in  1  input pixel valid.
- pix_i  in  PIX_W  input grayscale pixel.
- pix_ready_o  out  1  block can accept pix_i this cycle.
- out_valid_o  out  1  out_pix_o holds a result.
- out_pix_o  out  PIX_W  processed pixel.
- out_ready_i  in  1  downstream accepts out_pix_o.
- busy_o  out  1  high in RUN and DRAIN.
- frame_done_o  out  1  one-cycle pulse after final result is accepted.

## Operation
- FSM: IDLE -> RUN on start_i; RUN -> DRAIN after the last input pixel (col=X-1, row=Y-1) is accepted; DRAIN -> IDLE when the final output handshake completes, asserting frame_done_o for one cycle on that transition.
- start_i while not in IDLE: ignored, no state change.
- Input accepted when pix_valid_i && pix_ready_o. pix_ready_o = (state==RUN) && (!out_valid_o || out_ready_i).
- Counters col (0..X-1) and row (0..Y-1) of the incoming pixel; col wraps to 0 and row increments at col=X-1. Both cleared on accepted start.
- Line buffers: LB1 holds row r-1, LB0 holds row r-2, each IMG_X_SIZE x PIX_W; on each accepted pixel, LB0[col]<=LB1[col], LB1[col]<=pix_i.
- 3x3 window shift registers shift one column per accepted pixel (LB0[col], LB1[col], pix_i form the new right column). The window is valid only when row>=2 && col>=2; otherwise no output is produced. Contents left over from the previous row are don't-care.
- Window p[y][x], y=0 top, x=0 left. Gx=(p02+2p12+p22)-(p00+2p10+p20); Gy=(p20+2p21+p22)-(p00+2p01+p02); signed, PIX_W+3 bits.
- |G| fits in PIX_W+2 bits; the sum in PIX_W+3 bits, unsigned.
- Modes 0-2: the result saturates to 2^PIX_W-1.
- Mode 3: output is all-ones if |Gx|+|Gy| >= thresh_i (latched), otherwise 0.
- Output register: loaded on accepted input with a valid window; out_valid_o cleared on handshake unless reloaded in the same cycle.

## Timing
- Reset (rst_i low, asynchronous): state=IDLE; counters, out_valid_o, out_pix_o, busy_o, frame_done_o, pix_ready_o all 0. Line buffer contents are undefined.
- Reset mid-frame aborts the frame; there is no frame_done_o, and the next frame requires a new start_i.
- Latency: the result for window centre (r,c) appears on out_valid_o exactly 1 cycle after input pixel (r+1,c+1) is accepted.
- Throughput: 1 pixel/cycle when out_ready_i is held high.
- Stall: out_valid_o && !out_ready_i -> pix_ready_o=0. out_pix_o is held stable until the handshake. Accepting an input and releasing an output in the same cycle is allowed.
- The result count per frame is exactly (X-2)*(Y-2). frame_done_o is asserted the cycle after the last output handshake, together with busy_o falling.

## Test plan
- Constant frame of 60, X=5, Y=4, mode 2 -> exactly 6 outputs, all 0, then one frame_done_o pulse.
- Vertical step, X=5, Y=4, columns 0-1 = 0 and columns 2-4 = 100, mode 0 -> each output row is 255,255,0 (Gx=400 saturated). The same frame in mode 1 -> all 0.
- Mode 3, thresh_i=50: step height 10 (Gx=40) -> all 0. Step height 20 (Gx=80) -> 255,255,0.
- Hold out_ready_i low for 5 cycles mid-frame -> pix_ready_o=0 and out_pix_o stable throughout; after release, the output sequence is identical to the unstalled run.
- start_i pulsed during RUN is ignored, and mode_i changed mid-frame has no effect. After frame_done_o, a new start with a new mode processes the next frame correctly (line buffers reused).
- Assert rst_i low after 7 pixels -> all outputs 0 immediately, with no frame_done_o. A subsequent full frame produces the correct 6 results.

Source files
------------

// File: rtl/edge_detector_stream.sv
// Streaming 3x3 Sobel edge detector. It uses two line buffers and a sliding window,
// and has valid/ready handshakes on both the pixel input and the result output.
module edge_detector_stream #(
    parameter int PIX_W      = 8,
    parameter int IMG_X_SIZE = 100,
    parameter int IMG_Y_SIZE = 100
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        mode_i,
    input  logic [PIX_W+2:0]  thresh_i,
    input  logic              pix_valid_i,
    input  logic [PIX_W-1:0]  pix_i,
    output logic              pix_ready_o,
    output logic              out_valid_o,
    output logic [PIX_W-1:0]  out_pix_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              frame_done_o
);

    localparam int GW = PIX_W + 3;
    localparam int CW = $clog2(IMG_X_SIZE);
    localparam int RW = $clog2(IMG_Y_SIZE);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_X_SIZE - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Y_SIZE - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [GW-1:0] PIX_MAX  = {3'b000, {PIX_W{1'b1}}};

    logic [1:0]       state_r, state_s;
    logic [CW-1:0]    col_r;
    logic [RW-1:0]    row_r;
    logic [1:0]       mode_r;
    logic [GW-1:0]    thresh_r;
    logic             out_valid_r, busy_r, frame_done_r;
    logic [PIX_W-1:0] out_pix_r;

    logic [PIX_W-1:0] lb0_r [IMG_X_SIZE];
    logic [PIX_W-1:0] lb1_r [IMG_X_SIZE];
    // Only the two older window columns are stored; the newest column comes straight from LB0/LB1/pix_i.
    logic [PIX_W-1:0] win_r [3][2];
    logic [PIX_W-1:0] p_s   [3][3];

    logic                 pix_ready_s, accept_s, win_valid_s, col_last_s, row_last_s;
    logic signed [GW-1:0] gx_s, gy_s;
    logic [PIX_W+1:0]     agx_s, agy_s;
    logic [GW-1:0]        sum_s;
    logic [PIX_W-1:0]     result_s;

    function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
        return signed'({3'b000, v});
    endfunction

    function automatic logic [PIX_W+1:0] mag(input logic signed [GW-1:0] v);
        return v[GW-1] ? (PIX_W+2)'(-v) : (PIX_W+2)'(v);
    endfunction

    function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] v);
        if (v > PIX_MAX) begin
            return {PIX_W{1'b1}};
        end else begin
            return v[PIX_W-1:0];
        end
    endfunction

    // Handshake qualifiers and position flags
    always_comb begin
        pix_ready_s = (state_r == ST_RUN) && (!out_valid_r || out_ready_i);
        accept_s    = pix_valid_i && pix_ready_s;
        col_last_s  = (col_r == COL_LAST);
        row_last_s  = (row_r == ROW_LAST);
        win_valid_s = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
    end

    // Window as seen after the current pixel shifts in
    always_comb begin
        for (int y = 0; y < 3; y++) begin
            p_s[y][0] = win_r[y][0];
            p_s[y][1] = win_r[y][1];
        end
        p_s[0][2] = lb0_r[col_r];
        p_s[1][2] = lb1_r[col_r];
        p_s[2][2] = pix_i;
    end

    // Sobel gradients, magnitudes and mode selection
    always_comb begin
        gx_s  = (ext(p_s[0][2]) + (ext(p_s[1][2]) <<< 1) + ext(p_s[2][2]))
              - (ext(p_s[0][0]) + (ext(p_s[1][0]) <<< 1) + ext(p_s[2][0]));
        gy_s  = (ext(p_s[2][0]) + (ext(p_s[2][1]) <<< 1) + ext(p_s[2][2]))
              - (ext(p_s[0][0]) + (ext(p_s[0][1]) <<< 1) + ext(p_s[0][2]));
        agx_s = mag(gx_s);
        agy_s = mag(gy_s);
        sum_s = {1'b0, agx_s} + {1'b0, agy_s};
        case (mode_r)
            2'd0:    result_s = sat({1'b0, agx_s});
            2'd1:    result_s = sat({1'b0, agy_s});
            2'd2:    result_s = sat(sum_s);
            2'd3:    result_s = (sum_s >= thresh_r) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
            default: result_s = {PIX_W{1'b0}};
        endcase
    end

    // Next-state logic for the frame FSM
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_s = ST_RUN;
                else         state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (accept_s && col_last_s && row_last_s) state_s = ST_DRAIN;
                else                                      state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (out_valid_r && out_ready_i) state_s = ST_IDLE;
                else                            state_s = ST_DRAIN;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state, frame status flags, latched configuration and pixel counters
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            mode_r       <= 2'd0;
            thresh_r     <= {GW{1'b0}};
            col_r        <= {CW{1'b0}};
            row_r        <= {RW{1'b0}};
        end else begin
            state_r      <= state_s;
            busy_r       <= (state_s != ST_IDLE);
            frame_done_r <= (state_r == ST_DRAIN) && (state_s == ST_IDLE);
            if ((state_r == ST_IDLE) && start_i) begin
                mode_r   <= mode_i;
                thresh_r <= thresh_i;
                col_r    <= {CW{1'b0}};
                row_r    <= {RW{1'b0}};
            end else if (accept_s) begin
                if (col_last_s) begin
                    col_r <= {CW{1'b0}};
                    row_r <= row_last_s ? {RW{1'b0}} : row_r + RW'(1);
                end else begin
                    col_r <= col_r + CW'(1);
                end
            end
        end
    end

    // Result register: a reload takes priority over the release on handshake
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_valid_r <= 1'b0;
            out_pix_r   <= {PIX_W{1'b0}};
        end else if (accept_s && win_valid_s) begin
            out_valid_r <= 1'b1;
            out_pix_r   <= result_s;
        end else if (out_ready_i) begin
            out_valid_r <= 1'b0;
        end
    end

    // Line buffers and window storage carry no reset; stale contents never reach a valid window
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            lb0_r[col_r] <= lb1_r[col_r];
            lb1_r[col_r] <= pix_i;
            for (int y = 0; y < 3; y++) begin
                win_r[y][0] <= p_s[y][1];
                win_r[y][1] <= p_s[y][2];
            end
        end
    end

    assign pix_ready_o  = pix_ready_s;
    assign out_valid_o  = out_valid_r;
    assign out_pix_o    = out_pix_r;
    assign busy_o       = busy_r;
    assign frame_done_o = frame_done_r;

endmodule
